hazard_ctrl: RTL and testbench

//   Pipeline sequencing controller for the IF/ID and ID/EX stages. Detects

---
 rtl/hazard_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_hazard_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: sequencing controller for the IF/ID and ID/EX pipeline stages.
// It stalls on load-use hazards for LOAD_STALL_CYCLES cycles and flushes
// wrong-path stages on a taken branch. It freezes the whole pipeline while
// data memory is busy. It also keeps saturating stall and flush counters.
// The control outputs are Mealy: they depend on the state and the current inputs.
// The counters and the state are registered.

module hazard_ctrl #(
  parameter int unsigned LOAD_STALL_CYCLES = 1,
  parameter int unsigned CNT_W             = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      if_id_instr,
  input  logic             id_ex_mem_read,
  input  logic [4:0]       id_ex_rt,
  input  logic             ex_mem_branch_taken,
  input  logic             mem_busy,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             id_ex_write,
  output logic             ctl_bubble,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STALL  = 2'd1,
    ST_FREEZE = 2'd2
  } state_t;

  // Value loaded into the stall down-counter when a hazard is first seen;
  // the detecting cycle itself is the first of the stall cycles.
  localparam logic [3:0] STALL_INIT  = 4'(LOAD_STALL_CYCLES - 32'd1);
  localparam logic       MULTI_STALL = (LOAD_STALL_CYCLES > 32'd1);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;

  // Load-use detect. rs is always a source. rt is a source only for
  // R-type, store and beq instructions.
  function automatic logic hazard_detect(
    input logic        mem_read,
    input logic [4:0]  ld_rt,
    input logic [31:0] instr
  );
    logic       rt_is_src;
    logic       rs_hit;
    logic       rt_hit;
    rt_is_src = (instr[31:26] == OP_RTYPE) ||
                (instr[31:26] == OP_SW)    ||
                (instr[31:26] == OP_BEQ);
    rs_hit    = (ld_rt == instr[25:21]);
    rt_hit    = (ld_rt == instr[20:16]) && rt_is_src;
    return mem_read && (ld_rt != 5'd0) && (rs_hit || rt_hit);
  endfunction

  // Saturating increment: an all-ones counter holds instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
    logic [CNT_W-1:0] one_v;
    one_v = {{(CNT_W-1){1'b0}}, 1'b1};
    if (val == {CNT_W{1'b1}}) begin
      return val;
    end else begin
      return val + one_v;
    end
  endfunction

  state_t     state_r;
  state_t     ret_state_r;
  logic [3:0] cnt_r;

  state_t     eff_state_s;
  state_t     next_state_s;
  state_t     next_ret_s;
  logic [3:0] next_cnt_s;
  logic       hz_s;
  logic       stall_inc_s;
  logic       flush_inc_s;

  assign hz_s  = hazard_detect(id_ex_mem_read, id_ex_rt, if_id_instr);
  assign state = state_r;

  // The effective state is the state in which this cycle's inputs are acted on.
  // In the first cycle after a freeze this is the saved state. That cycle then
  // counts as a normal stall or idle cycle.
  always_comb begin
    eff_state_s = ST_IDLE;
    case (state_r)
      ST_IDLE:   eff_state_s = ST_IDLE;
      ST_STALL:  eff_state_s = ST_STALL;
      ST_FREEZE: eff_state_s = ret_state_r;
      default:   eff_state_s = ST_IDLE;
    endcase
  end

  // Mealy control outputs and next-state logic.
  // Priority, highest first: rst, then mem_busy, then branch, then stall/hazard.
  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    id_ex_write  = 1'b1;
    ctl_bubble   = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    next_state_s = eff_state_s;
    next_ret_s   = ret_state_r;
    next_cnt_s   = cnt_r;
    stall_inc_s  = 1'b0;
    flush_inc_s  = 1'b0;
    if (rst) begin
      next_state_s = ST_IDLE;
      next_ret_s   = ST_IDLE;
      next_cnt_s   = 4'd0;
    end else if (mem_busy) begin
      // Freeze everything, keep cnt, remember where to resume.
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_write  = 1'b0;
      next_state_s = ST_FREEZE;
      next_ret_s   = eff_state_s;
    end else if (ex_mem_branch_taken) begin
      // Wrong-path work, including any pending stall, is discarded.
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      next_state_s = ST_IDLE;
      next_cnt_s   = 4'd0;
      flush_inc_s  = 1'b1;
    end else if (eff_state_s == ST_STALL) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      ctl_bubble  = 1'b1;
      stall_inc_s = 1'b1;
      if (cnt_r <= 4'd1) begin
        next_state_s = ST_IDLE;
        next_cnt_s   = 4'd0;
      end else begin
        next_state_s = ST_STALL;
        next_cnt_s   = cnt_r - 4'd1;
      end
    end else if (hz_s) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      ctl_bubble  = 1'b1;
      stall_inc_s = 1'b1;
      if (MULTI_STALL) begin
        next_state_s = ST_STALL;
        next_cnt_s   = STALL_INIT;
      end else begin
        // The bubble clears id_ex_mem_read, so the hazard is not seen again.
        next_state_s = ST_IDLE;
        next_cnt_s   = 4'd0;
      end
    end else begin
      next_state_s = ST_IDLE;
    end
  end

  // State, saved return state and stall down-counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      ret_state_r <= ST_IDLE;
      cnt_r       <= 4'd0;
    end else begin
      state_r     <= next_state_s;
      ret_state_r <= next_ret_s;
      cnt_r       <= next_cnt_s;
    end
  end

  // Saturating performance counters for stall cycles and branch flushes.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count <= {CNT_W{1'b0}};
      flush_count <= {CNT_W{1'b0}};
    end else begin
      if (stall_inc_s) begin
        stall_count <= sat_inc(stall_count);
      end else begin
        stall_count <= stall_count;
      end
      if (flush_inc_s) begin
        flush_count <= sat_inc(flush_count);
      end else begin
        flush_count <= flush_count;
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Testbench for hazard_ctrl. It uses three instances that share the same stimulus:
// u_n1 has a 1-cycle stall, u_n3 has a 3-cycle stall, and u_sat has a 3-cycle
// stall with 2-bit counters so that counter saturation is reached quickly.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        mr;
  logic [4:0]  rt;
  logic        br;
  logic        busy;

  logic        n1_pc, n1_ifw, n1_exw, n1_bub, n1_iff, n1_exf;
  logic [15:0] n1_stall, n1_flush;
  logic [1:0]  n1_state;
  logic        n3_pc, n3_ifw, n3_exw, n3_bub, n3_iff, n3_exf;
  logic [15:0] n3_stall, n3_flush;
  logic [1:0]  n3_state;
  logic        s_pc, s_ifw, s_exw, s_bub, s_iff, s_exf;
  logic [1:0]  s_stall, s_flush;
  logic [1:0]  s_state;

  logic [5:0]  n1_ctl, n3_ctl;
  assign n1_ctl = {n1_pc, n1_ifw, n1_exw, n1_bub, n1_iff, n1_exf};
  assign n3_ctl = {n3_pc, n3_ifw, n3_exw, n3_bub, n3_iff, n3_exf};

  int n_tests = 0;
  int n_fail  = 0;

  // {pc_write, if_id_write, id_ex_write, ctl_bubble, if_id_flush, id_ex_flush}
  localparam logic [5:0] RUN   = 6'b111000;
  localparam logic [5:0] STALL = 6'b001100;
  localparam logic [5:0] FLUSH = 6'b111011;
  localparam logic [5:0] FRZ   = 6'b000000;

  localparam logic [31:0] I_ADD  = 32'h00A13020; // add r6,r5,r1
  localparam logic [31:0] I_ADD0 = 32'h00003020; // add r6,r0,r0
  localparam logic [31:0] I_SW   = 32'hAC450000; // sw r5,0(r2)
  localparam logic [31:0] I_ADDI = 32'h20470004; // addi r7,r2,4
  localparam logic [31:0] I_BEQ  = 32'h10650000; // beq r3,r5
  localparam logic [31:0] I_LW   = 32'h8CA60000; // lw r6,0(r5)

  typedef struct {
    logic [31:0] instr;
    logic        mr;
    logic [4:0]  rt;
    logic        br;
    logic        busy;
    logic [5:0]  exp_ctl;
    logic [1:0]  exp_state;
  } vec_t;

  vec_t vecs [14];

  always #5 clk = ~clk;

  hazard_ctrl #(.LOAD_STALL_CYCLES(1), .CNT_W(16)) u_n1 (
    .clk(clk), .rst(rst), .if_id_instr(instr), .id_ex_mem_read(mr), .id_ex_rt(rt),
    .ex_mem_branch_taken(br), .mem_busy(busy), .pc_write(n1_pc), .if_id_write(n1_ifw),
    .id_ex_write(n1_exw), .ctl_bubble(n1_bub), .if_id_flush(n1_iff), .id_ex_flush(n1_exf),
    .stall_count(n1_stall), .flush_count(n1_flush), .state(n1_state));

  hazard_ctrl #(.LOAD_STALL_CYCLES(3), .CNT_W(16)) u_n3 (
    .clk(clk), .rst(rst), .if_id_instr(instr), .id_ex_mem_read(mr), .id_ex_rt(rt),
    .ex_mem_branch_taken(br), .mem_busy(busy), .pc_write(n3_pc), .if_id_write(n3_ifw),
    .id_ex_write(n3_exw), .ctl_bubble(n3_bub), .if_id_flush(n3_iff), .id_ex_flush(n3_exf),
    .stall_count(n3_stall), .flush_count(n3_flush), .state(n3_state));

  hazard_ctrl #(.LOAD_STALL_CYCLES(3), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .if_id_instr(instr), .id_ex_mem_read(mr), .id_ex_rt(rt),
    .ex_mem_branch_taken(br), .mem_busy(busy), .pc_write(s_pc), .if_id_write(s_ifw),
    .id_ex_write(s_exw), .ctl_bubble(s_bub), .if_id_flush(s_iff), .id_ex_flush(s_exf),
    .stall_count(s_stall), .flush_count(s_flush), .state(s_state));

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk3(input string nm, input logic [5:0] ctl, input logic [1:0] st);
    check({nm, "_ctl"}, 32'(n3_ctl), 32'(ctl));
    check({nm, "_st"}, 32'(n3_state), 32'(st));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] i, input logic m, input logic [4:0] r,
                       input logic b, input logic bz);
    instr = i; mr = m; rt = r; br = b; busy = bz;
  endtask

  initial begin
    vecs[0]  = '{I_ADD,  1'b1, 5'd5, 1'b0, 1'b0, STALL, 2'd0};
    vecs[1]  = '{I_ADD,  1'b0, 5'd5, 1'b0, 1'b0, RUN,   2'd0};
    vecs[2]  = '{I_ADD0, 1'b1, 5'd0, 1'b0, 1'b0, RUN,   2'd0};
    vecs[3]  = '{I_SW,   1'b1, 5'd5, 1'b0, 1'b0, STALL, 2'd0};
    vecs[4]  = '{I_ADDI, 1'b1, 5'd7, 1'b0, 1'b0, RUN,   2'd0};
    vecs[5]  = '{I_BEQ,  1'b1, 5'd5, 1'b0, 1'b0, STALL, 2'd0};
    vecs[6]  = '{I_LW,   1'b1, 5'd6, 1'b0, 1'b0, RUN,   2'd0};
    vecs[7]  = '{I_LW,   1'b1, 5'd5, 1'b0, 1'b0, STALL, 2'd0};
    vecs[8]  = '{I_ADD,  1'b1, 5'd5, 1'b1, 1'b0, FLUSH, 2'd0};
    vecs[9]  = '{I_ADD,  1'b1, 5'd5, 1'b1, 1'b1, FRZ,   2'd0};
    vecs[10] = '{I_ADD,  1'b0, 5'd5, 1'b1, 1'b0, FLUSH, 2'd2};
    vecs[11] = '{I_ADD,  1'b1, 5'd5, 1'b0, 1'b1, FRZ,   2'd0};
    vecs[12] = '{I_ADD,  1'b1, 5'd5, 1'b0, 1'b1, FRZ,   2'd2};
    vecs[13] = '{I_ADD,  1'b0, 5'd5, 1'b0, 1'b0, RUN,   2'd2};

    rst = 1'b1;
    drive(I_ADD, 1'b1, 5'd5, 1'b1, 1'b0);
    #1;
    check("rst_ctl_override", 32'(n1_ctl), 32'(RUN));
    tick(); tick();
    check("rst_state", 32'(n1_state), 32'd0);
    check("rst_stall_cnt", 32'(n1_stall), 32'd0);
    check("rst_flush_cnt", 32'(n1_flush), 32'd0);
    rst = 1'b0;

    // Single-cycle vectors against the N=1 instance.
    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].instr, vecs[i].mr, vecs[i].rt, vecs[i].br, vecs[i].busy);
      #1;
      check($sformatf("vec%0d_ctl", i), 32'(n1_ctl), 32'(vecs[i].exp_ctl));
      check($sformatf("vec%0d_state", i), 32'(n1_state), 32'(vecs[i].exp_state));
      tick();
    end
    drive(I_ADD, 1'b0, 5'd5, 1'b0, 1'b0);
    #1;
    check("vec_end_state", 32'(n1_state), 32'd0);
    check("vec_stall_cnt", 32'(n1_stall), 32'd4);
    check("vec_flush_cnt", 32'(n1_flush), 32'd2);

    // Reset all instances before the multi-cycle sequences.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("n3_rst_state", 32'(n3_state), 32'd0);

    // N=3 load-use: sw r5 behind lw r5.
    drive(I_SW, 1'b1, 5'd5, 1'b0, 1'b0);
    #1; chk3("t2c1", STALL, 2'd0); tick();
    chk3("t2c2", STALL, 2'd1); tick();
    chk3("t2c3", STALL, 2'd1); tick();
    mr = 1'b0;
    #1; chk3("t2c4", RUN, 2'd0);
    check("t2_stall_cnt", 32'(n3_stall), 32'd3);
    check("t2_flush_cnt", 32'(n3_flush), 32'd0);
    check("t2_sat_stall", 32'(s_stall), 32'd3);

    // Branch on the second STALL-state cycle abandons the stall.
    mr = 1'b1;
    #1; chk3("t4c1", STALL, 2'd0); tick();
    chk3("t4c2", STALL, 2'd1); tick();
    br = 1'b1;
    #1; chk3("t4c3", FLUSH, 2'd1); tick();
    br = 1'b0; mr = 1'b0;
    #1; chk3("t4c4", RUN, 2'd0);
    check("t4_stall_cnt", 32'(n3_stall), 32'd5);
    check("t4_flush_cnt", 32'(n3_flush), 32'd1);
    check("t4_sat_stall_hold", 32'(s_stall), 32'd3);

    // Three more branches drive the 2-bit flush counter into saturation.
    br = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1; chk3($sformatf("sat_br%0d", k), FLUSH, 2'd0);
      tick();
    end
    br = 1'b0;
    #1;
    check("sat_n3_flush", 32'(n3_flush), 32'd4);
    check("sat_flush_hold", 32'(s_flush), 32'd3);

    // A 4-cycle freeze in the middle of a stall, then the stall resumes.
    mr = 1'b1;
    #1; chk3("t5c1", STALL, 2'd0); tick();
    busy = 1'b1;
    #1; chk3("t5f1", FRZ, 2'd1); tick();
    chk3("t5f2", FRZ, 2'd2); tick();
    chk3("t5f3", FRZ, 2'd2); tick();
    chk3("t5f4", FRZ, 2'd2); tick();
    check("t5_stall_frozen", 32'(n3_stall), 32'd6);
    busy = 1'b0;
    #1; chk3("t5r1", STALL, 2'd2); tick();
    chk3("t5r2", STALL, 2'd1); tick();
    mr = 1'b0;
    #1; chk3("t5end", RUN, 2'd0);
    check("t5_stall_cnt", 32'(n3_stall), 32'd8);

    // Reset in the middle of a stall.
    mr = 1'b1;
    #1; chk3("t6c1", STALL, 2'd0); tick();
    chk3("t6c2", STALL, 2'd1);
    rst = 1'b1;
    #1; chk3("t6rst", RUN, 2'd1); tick();
    rst = 1'b0; mr = 1'b0;
    #1;
    check("t6_state", 32'(n3_state), 32'd0);
    check("t6_stall_cnt", 32'(n3_stall), 32'd0);
    check("t6_flush_cnt", 32'(n3_flush), 32'd0);
    check("t6_sat_flush", 32'(s_flush), 32'd0);
    check("t6_n1_stall", 32'(n1_stall), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
